// File: rtl/inst_mem_resp.sv
// rtl/inst_mem_resp.sv - instruction memory with combinational fetch port and byte-stream loader
//
// Purpose:
//   Serves CPU instruction fetches with a same-cycle read of a 2^ADDR_W x 32
//   word array. A byte-stream loader FSM assembles big-endian words from a
//   host/boot source and writes them into the array.
//
// Ports:
//   clk          clock, rising-edge active
//   rst          asynchronous active-low reset
//   rom_ce_i     fetch enable
//   rom_addr_i   fetch byte address; word index is rom_addr_i[ADDR_W+1:2]
//   rom_data_o   fetched instruction, 0 when disabled, loading or in reset
//   ld_start_i   begin or restart a load at word 0
//   ld_valid_i   loader byte valid
//   ld_byte_i    loader byte
//   ld_last_i    marks the final byte of the image
//   ld_ready_o   high for the whole of LOAD
//   busy_o       high while in LOAD
//   ld_done_o    one-cycle pulse after the final write of a load
//   ld_words_o   words written by the last completed load

module inst_mem_resp #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              busy_o,
  output logic              ld_done_o,
  output logic [ADDR_W:0]   ld_words_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [23:0]         buf_q, buf_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     words_q, words_d;

  logic                we;
  logic [31:0]         wdata;
  logic                load_end;

  logic [31:0]         mem [DEPTH];

  // Only the word-index bits of the fetch address select a word.
  logic unused_addr;
  assign unused_addr = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

  always_comb begin
    rom_data_o = 32'h0;
    if (rst && rom_ce_i && (state_q == IDLE)) begin
      rom_data_o = mem[rom_addr_i[ADDR_W+1:2]];
    end
  end

  assign ld_ready_o = (state_q == LOAD);
  assign busy_o     = (state_q == LOAD);
  assign ld_done_o  = done_q;
  assign ld_words_o = words_q;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    done_d   = 1'b0;
    words_d  = words_q;
    we       = 1'b0;
    load_end = 1'b0;
    // Left-align the bytes gathered so far plus the incoming byte; for a
    // full word the shift is zero, for a short final word the low bytes
    // fill with zeros.
    wdata    = {buf_q, ld_byte_i} << {2'd3 - cnt_q, 3'b000};

    case (state_q)
      IDLE: begin
        if (ld_start_i) begin
          state_d = LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
          buf_d   = '0;
        end
      end
      LOAD: begin
        if (ld_start_i) begin
          // Restart wins over a byte presented in the same cycle.
          wptr_d = '0;
          cnt_d  = '0;
          buf_d  = '0;
        end else if (ld_valid_i) begin
          buf_d = {buf_q[15:0], ld_byte_i};
          cnt_d = cnt_q + 2'd1;
          if (ld_last_i || (cnt_q == 2'd3)) begin
            we = 1'b1;
          end
          // A full word landing in the last slot ends the load, so the
          // array never wraps onto word 0.
          load_end = ld_last_i ||
                     ((cnt_q == 2'd3) && (wptr_q == {ADDR_W{1'b1}}));
          if (load_end) begin
            state_d = IDLE;
            done_d  = 1'b1;
            words_d = {1'b0, wptr_q} + {{ADDR_W{1'b0}}, 1'b1};
          end else if (cnt_q == 2'd3) begin
            wptr_d = wptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
      words_q <= words_d;
    end
  end

  // The array has no reset; contents survive reset and restarts.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wptr_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_inst_mem_resp.sv
// tb/tb_inst_mem_resp.sv - self-checking bench for inst_mem_resp
module tb_inst_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_last = 1'b0;

  logic [31:0] rom_data, rom_data2;
  logic        ld_ready, busy, done;
  logic        ld_ready2, busy2, done2;
  logic [10:0] words;
  logic [2:0]  words2;

  logic [31:0] model_mem [1024];
  logic [31:0] model_mem2 [4];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  inst_mem_resp #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data),
    .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(ld_ready), .busy_o(busy), .ld_done_o(done), .ld_words_o(words)
  );

  inst_mem_resp #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rom_data2),
    .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(ld_ready2), .busy_o(busy2), .ld_done_o(done2), .ld_words_o(words2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: an image of n bytes occupies ceil(n/4) words, packed
  // big-endian with zero fill in the final word.
  function automatic int model_load(input logic [7:0] b[$]);
    int nw;
    logic [31:0] w;
    nw = (b.size() + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        if (4 * i + j < b.size()) w = w | (32'(b[4 * i + j]) << (24 - 8 * j));
      end
      model_mem[i] = w;
    end
    return nw;
  endfunction

  task automatic send_stream(input logic [7:0] b[$], input bit last_end, input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0;
          step();
        end
      end
      ld_valid = 1'b1;
      ld_byte  = b[i];
      ld_last  = last_end && (i == b.size() - 1);
      checks++;
      if (ld_ready !== 1'b1) $display("FAIL ready_in_load byte %0d: got %b want 1", i, ld_ready);
      else passed++;
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] b[$], input string name);
    int exp;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy: got %b want 1", name, busy);
    else passed++;
    send_stream(b, 1'b1, 1'b1);
    exp = model_load(b);
    checks++;
    if (done !== 1'b1 || words !== 11'(exp) || busy !== 1'b0)
      $display("FAIL %s end: done=%b words=%0d busy=%b want 1/%0d/0", name, done, words, busy, exp);
    else passed++;
    step();
    checks++;
    if (done !== 1'b0 || words !== 11'(exp))
      $display("FAIL %s after: done=%b words=%0d want 0/%0d", name, done, words, exp);
    else passed++;
  endtask

  task automatic check_fetch(input int idx, input string name);
    rom_ce   = 1'b1;
    rom_addr = ($urandom() & ~32'hFFF) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
    #1;
    checks++;
    if (rom_data !== model_mem[idx])
      $display("FAIL %s fetch[%0d] addr=%h: got %h want %h", name, idx, rom_addr, rom_data, model_mem[idx]);
    else passed++;
    rom_ce = 1'b0;
  endtask

  task automatic test_reset();
    rom_ce   = 1'b1;
    rom_addr = 32'h0;
    #12;
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || words !== 11'd0 || rom_data !== 32'h0)
      $display("FAIL reset: ready=%b busy=%b done=%b words=%0d data=%h want 0", ld_ready, busy, done, words, rom_data);
    else passed++;
    rom_ce = 1'b0;
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_basic_load();
    logic [7:0] q[$];
    q = '{8'h34, 8'h01, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h0C};
    do_load(q, "basic");
    rom_ce = 1'b1;
    rom_addr = 32'h4;
    #1;
    checks++;
    if (rom_data !== 32'h0000000C) $display("FAIL basic_addr4: got %h want 0000000c", rom_data);
    else passed++;
    rom_ce = 1'b0;
    check_fetch(0, "basic");
  endtask

  task automatic test_partial();
    logic [7:0] q[$];
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_load(q, "partial");
    check_fetch(0, "partial");
    check_fetch(1, "partial");
  endtask

  task automatic test_fetch_gating();
    logic [7:0] q[$];
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    rom_ce = 1'b1;
    rom_addr = 32'h0;
    #1;
    checks++;
    if (rom_data !== 32'h0 || busy !== 1'b1)
      $display("FAIL fetch_in_load: data=%h busy=%b want 0/1", rom_data, busy);
    else passed++;
    rom_ce = 1'b0;
    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_stream(q, 1'b1, 1'b0);
    void'(model_load(q));
    step();
    rom_ce = 1'b0;
    rom_addr = 32'h0;
    #1;
    checks++;
    if (rom_data !== 32'h0) $display("FAIL fetch_ce0: got %h want 0", rom_data);
    else passed++;
    rom_ce = 1'b1;
    rom_addr = 32'h1003;
    #1;
    checks++;
    if (rom_data !== 32'h12345678) $display("FAIL fetch_wrap: got %h want 12345678", rom_data);
    else passed++;
    rom_ce = 1'b0;
  endtask

  task automatic test_restart();
    logic [7:0] q[$];
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    q = '{8'h01, 8'h02};
    send_stream(q, 1'b0, 1'b0);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'h11;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    q = '{8'h22, 8'h33, 8'h44, 8'h55};
    send_stream(q, 1'b1, 1'b0);
    void'(model_load(q));
    checks++;
    if (done !== 1'b1 || words !== 11'd1) $display("FAIL restart_end: done=%b words=%0d want 1/1", done, words);
    else passed++;
    step();
    check_fetch(0, "restart");
  endtask

  task automatic test_reset_midload();
    logic [7:0] q[$];
    logic [31:0] old1;
    old1 = model_mem[1];
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    q = '{8'hC0, 8'hFF, 8'hEE, 8'h01, 8'h77, 8'h88};
    send_stream(q, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0 || words !== 11'd0)
      $display("FAIL reset_midload: ready=%b busy=%b words=%0d want 0/0/0", ld_ready, busy, words);
    else passed++;
    #2 rst = 1'b1;
    step();
    model_mem[0] = 32'hC0FFEE01;
    check_fetch(0, "reset_midload");
    checks++;
    if (model_mem[1] !== old1) $display("FAIL reset_midload_model: got %h want %h", model_mem[1], old1);
    else passed++;
    check_fetch(1, "reset_midload");
  endtask

  task automatic test_full();
    logic [7:0] q[$];
    q = {};
    for (int i = 0; i < 17; i++) q.push_back(8'($urandom()));
    for (int i = 0; i < 4; i++)
      model_mem2[i] = {q[4 * i], q[4 * i + 1], q[4 * i + 2], q[4 * i + 3]};
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_byte  = q[i];
      checks++;
      if (ld_ready2 !== 1'b1) $display("FAIL full_ready byte %0d: got %b want 1", i, ld_ready2);
      else passed++;
      step();
    end
    checks++;
    if (done2 !== 1'b1 || words2 !== 3'd4 || busy2 !== 1'b0)
      $display("FAIL full_end: done=%b words=%0d busy=%b want 1/4/0", done2, words2, busy2);
    else passed++;
    ld_byte = q[16];
    ld_last = 1'b1;
    #1;
    checks++;
    if (ld_ready2 !== 1'b0) $display("FAIL full_17th_ready: got %b want 0", ld_ready2);
    else passed++;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    checks++;
    if (done2 !== 1'b0 || words2 !== 3'd4) $display("FAIL full_hold: done=%b words=%0d want 0/4", done2, words2);
    else passed++;
    checks++;
    if (done !== 1'b1 || words !== 11'd5) $display("FAIL big_17: done=%b words=%0d want 1/5", done, words);
    else passed++;
    void'(model_load(q));
    step();
    for (int i = 0; i < 4; i++) begin
      rom_ce = 1'b1;
      rom_addr = ($urandom() & ~32'hF) | (32'(i) << 2);
      #1;
      checks++;
      if (rom_data2 !== model_mem2[i])
        $display("FAIL full_fetch[%0d]: got %h want %h", i, rom_data2, model_mem2[i]);
      else passed++;
    end
    rom_ce = 1'b0;
    for (int i = 0; i < 5; i++) check_fetch(i, "big_17");
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int n;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 24);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom()));
      do_load(q, $sformatf("random%0d", t));
      for (int i = 0; i < (n + 3) / 4; i++) check_fetch(i, $sformatf("random%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_partial();
    test_fetch_gating();
    test_restart();
    test_reset_midload();
    test_full();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
